// File: rtl/uart_echo_responder.sv
// Echo peer: queues bytes from UART_RX and replays them to UART_TX, one start pulse per byte.
// Optional feature macro: UART_ECHO_CASE_SWAP_EN (swap ASCII letter case on the output path).
module uart_echo_responder #(
    parameter int DEPTH        = 8,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    input  logic                   tx_busy,
    input  logic                   clr_ovf,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow,
    output logic [7:0]             drop_cnt,
    output logic                   timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   wait_q, wait_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [7:0]      tx_data_q;
    logic            timeout_q, timeout_d;
    logic            overflow_q;
    logic [7:0]      drop_q;
    logic [7:0]      mem [DEPTH];
    logic            pop, push, drop;
    logic [7:0]      head_byte, out_byte;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        pop       = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                // A busy line left over from before reset holds us here until it drops.
                if (count_q != '0 && !tx_busy) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                wait_d  = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (wait_q == TW'(BUSY_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push = rx_valid && (count_q != CW'(DEPTH) || pop);
    assign drop = rx_valid && !push;

    assign head_byte = mem[rd_ptr_q];
`ifdef UART_ECHO_CASE_SWAP_EN
    assign out_byte = ((head_byte >= 8'h41 && head_byte <= 8'h5A) ||
                       (head_byte >= 8'h61 && head_byte <= 8'h7A)) ? (head_byte ^ 8'h20) : head_byte;
`else
    assign out_byte = head_byte;
`endif

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_data_q  <= 8'h00;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= 8'h00;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                tx_data_q <= out_byte;
            end
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
            if (clr_ovf) begin
                overflow_q <= 1'b0;
                drop_q     <= 8'h00;
            end else if (drop) begin
                overflow_q <= 1'b1;
                if (drop_q != 8'hFF) drop_q <= drop_q + 1'b1;
            end
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_start   = (state_q == START);
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign drop_cnt   = drop_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_uart_echo_responder.sv
// Bench for uart_echo_responder: scoreboard of expected TX bytes plus a small UART_TX model.
module tb_uart_echo_responder;
    localparam int DEPTH = 8;
    localparam int BT    = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_busy;
    logic       clr_ovf;
    logic [7:0] tx_data;
    logic       tx_start;
    logic [3:0] fifo_count;
    logic       overflow;
    logic [7:0] drop_cnt;
    logic       timeout;

    uart_echo_responder #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BT)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_busy(tx_busy), .clr_ovf(clr_ovf), .tx_data(tx_data), .tx_start(tx_start),
        .fifo_count(fifo_count), .overflow(overflow), .drop_cnt(drop_cnt), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef enum {M_AUTO, M_HOLD, M_DEAD, M_MANUAL} mode_t;
    mode_t      tx_mode  = M_AUTO;
    logic       man_busy = 1'b0;
    int         n_chk = 0, n_err = 0;
    int         cyc = 0, n_start = 0, n_tmo = 0, last_start_cyc = 0;
    int         s0, t0;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
        chk(tag, exp_q.size(), 0);
        tick(10);
    endtask

    always @(posedge clk) cyc++;

    // UART_TX stand-in: busy for 5 cycles after each start, or forced per mode.
    initial begin
        int left;
        left    = 0;
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (tx_mode)
                M_HOLD:   tx_busy = 1'b1;
                M_DEAD:   tx_busy = 1'b0;
                M_MANUAL: tx_busy = man_busy;
                default: begin
                    if (tx_start) left = 5;
                    if (left > 0) begin
                        tx_busy = 1'b1;
                        left--;
                    end else begin
                        tx_busy = 1'b0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            n_start++;
            last_start_cyc = cyc;
            if (exp_q.size() == 0) chk("unexpected_start", 1, 0);
            else                   chk("tx_byte", tx_data, exp_q.pop_front());
        end
        if (timeout === 1'b1) begin
            n_tmo++;
            chk("timeout_delay", cyc - last_start_cyc, BT + 1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] t6_in  [3];
        logic [7:0] t6_exp [3];
        t6_in  = '{8'h61, 8'h5A, 8'h31};
`ifdef UART_ECHO_CASE_SWAP_EN
        t6_exp = '{8'h41, 8'h7A, 8'h31};
`else
        t6_exp = '{8'h61, 8'h5A, 8'h31};
`endif
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; clr_ovf = 1'b0;
        tick(3);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_timeout", timeout, 0);
        rst = 1'b0;
        tick();

        // single byte latency
        rx_data = 8'hA5; rx_valid = 1'b1; exp_q.push_back(8'hA5);
        tick();
        rx_valid = 1'b0;
        chk("t1_count1", fifo_count, 1);
        tick();
        chk("t1_start", tx_start, 1);
        chk("t1_data", tx_data, 8'hA5);
        chk("t1_count0", fifo_count, 0);
        drain("t1_drain");

        // overflow burst while TX is held busy
        tx_mode = M_HOLD;
        tick();
        for (int i = 0; i < DEPTH + 2; i++) begin
            rx_data  = 8'(8'h10 + i);
            rx_valid = 1'b1;
            if (i < DEPTH) exp_q.push_back(rx_data);
            tick();
        end
        rx_valid = 1'b0;
        tick();
        chk("t2_count_full", fifo_count, DEPTH);
        chk("t2_overflow", overflow, 1);
        chk("t2_drop", drop_cnt, 2);
        s0 = n_start;
        tx_mode = M_AUTO;
        drain("t2_drain");
        chk("t2_sent", n_start - s0, DEPTH);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("t2_clr_overflow", overflow, 0);
        chk("t2_clr_drop", drop_cnt, 0);

        // full FIFO with push and pop in the same cycle
        tx_mode = M_MANUAL; man_busy = 1'b1;
        tick();
        s0 = n_start;
        for (int i = 0; i < DEPTH; i++) begin
            rx_data = 8'(8'h20 + i); rx_valid = 1'b1; exp_q.push_back(rx_data);
            tick();
        end
        man_busy = 1'b0; rx_data = 8'h77; exp_q.push_back(8'h77);
        tick();
        rx_valid = 1'b0; man_busy = 1'b1;
        chk("t3_count", fifo_count, DEPTH);
        chk("t3_overflow", overflow, 0);
        chk("t3_drop", drop_cnt, 0);
        chk("t3_start", tx_start, 1);
        tick(2);
        tx_mode = M_AUTO;
        drain("t3_drain");
        chk("t3_sent", n_start - s0, DEPTH + 1);

        // TX never asserts busy: abort after the timeout, next byte still served
        tx_mode = M_DEAD;
        t0 = n_tmo; s0 = n_start;
        rx_data = 8'h3C; rx_valid = 1'b1; exp_q.push_back(8'h3C);
        tick();
        rx_data = 8'h4D; exp_q.push_back(8'h4D);
        tick();
        rx_valid = 1'b0;
        for (int i = 0; i < 400 && (n_tmo - t0) < 2; i++) tick();
        chk("t4_timeouts", n_tmo - t0, 2);
        chk("t4_sent", n_start - s0, 2);
        chk("t4_empty", exp_q.size(), 0);
        tick(3);

        // reset while in WAIT_DONE with three bytes still queued
        tx_mode = M_MANUAL; man_busy = 1'b1;
        tick();
        s0 = n_start;
        for (int i = 0; i < 4; i++) begin
            rx_data = 8'(8'h51 + i); rx_valid = 1'b1;
            if (i == 0) exp_q.push_back(rx_data);
            tick();
        end
        rx_valid = 1'b0; man_busy = 1'b0;
        tick();
        man_busy = 1'b1;
        tick(2);
        chk("t5_count_before", fifo_count, 3);
        rst = 1'b1;
        tick();
        chk("t5_tx_start", tx_start, 0);
        chk("t5_tx_data", tx_data, 0);
        chk("t5_count", fifo_count, 0);
        chk("t5_timeout", timeout, 0);
        rst = 1'b0;
        tick(5);
        man_busy = 1'b0;
        tick(20);
        chk("t5_no_more_start", n_start - s0, 1);

        // case-swap output path
        tx_mode = M_AUTO;
        tick();
        for (int i = 0; i < 3; i++) begin
            rx_data = t6_in[i]; rx_valid = 1'b1; exp_q.push_back(t6_exp[i]);
            tick();
        end
        rx_valid = 1'b0;
        drain("t6_drain");

        chk("final_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
